// File: rtl/simple_proc_pkg.sv
// Shared definitions for the simple processor and its instruction fetch unit.
// Contents:
//   DATA_W              instruction/data word width
//   field localparams   bit positions of opcode, X and Y within a word
//   opcode_e            processor opcodes (MV, MVI, ADD, SUB)
//   fetch_state_t       fetch unit FSM states
//   opcode_of()         extracts the opcode field from a word
package simple_proc_pkg;

   localparam int DATA_W  = 9;
   localparam int FIELD_W = 3;
   localparam int OPC_LSB = 0;
   localparam int X_LSB   = 3;
   localparam int Y_LSB   = 6;

   typedef enum logic [2:0] {
      OP_MV  = 3'b000,
      OP_MVI = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_IMM   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HALT  = 3'd4,
      ST_ERR   = 3'd5
   } fetch_state_t;

   function automatic logic [FIELD_W-1:0] opcode_of(input logic [DATA_W-1:0] word);
      return word[OPC_LSB +: FIELD_W];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_prog_ram.sv
// Program RAM for the instruction fetch unit.
// DEPTH x DATA_W words, synchronous write, asynchronous read. Contents are
// not reset.
// Ports:
//   clk_i    in  clock, rising edge
//   we_i     in  write strobe
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out read data (combinational from raddr_i)
module prog_ram #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Storage write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds a loadable program RAM and feeds the
// processor one instruction at a time (plus the immediate word after mvi),
// pacing on Done.
// Optional feature macro: FETCH_TIMEOUT_EN (WAIT watchdog, drives err).
// Ports:
//   Clock      in  clock, rising edge
//   Resetn     in  asynchronous active-low reset
//   start      in  pulse: run program from address 0 (only when not busy)
//   prog_len   in  number of valid program words, sampled on start
//   prog_we    in  program RAM write strobe (dropped while busy)
//   prog_addr  in  program RAM write address
//   prog_data  in  program RAM write data
//   Done       in  processor instruction-complete flag
//   DIN        out word presented to the processor (registered)
//   Run        out one-cycle instruction-issue strobe (registered)
//   pc         out address of the next word to fetch
//   busy       out program executing (ISSUE/IMM/WAIT)
//   halted     out program ran to completion
//   err        out watchdog fired (0 without FETCH_TIMEOUT_EN)
module instr_fetch_unit #(
   parameter int DATA_W  = simple_proc_pkg::DATA_W,
   parameter int DEPTH   = 32,
   parameter int TIMEOUT = 64,
   parameter int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              Done,
   output logic [DATA_W-1:0] DIN,
   output logic              Run,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic              err
);
   import simple_proc_pkg::*;

   // The program counter carries one extra bit so that len==DEPTH can be
   // matched after the address part has wrapped.
   localparam int CNT_W = ADDR_W + 1;

   fetch_state_t      state_q, state_d;
   logic [CNT_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              run_q, run_d;
   logic              busy_q, busy_d;
   logic              halted_q, halted_d;
   logic [DATA_W-1:0] rdata_s;

`ifdef FETCH_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              err_q, err_d;
`endif

   // Reads are addressed with the next pc so DIN can be registered while
   // still showing mem[pc] during the ISSUE/IMM cycle itself.
   prog_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_prog_ram (
      .clk_i   (Clock),
      .we_i    (prog_we & ~busy_q),
      .waddr_i (prog_addr),
      .wdata_i (prog_data),
      .raddr_i (pc_d[ADDR_W-1:0]),
      .rdata_o (rdata_s)
   );

   // Next-state logic for the fetch FSM, pc, length and watchdog
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
`ifdef FETCH_TIMEOUT_EN
      wd_d    = wd_q;
`endif
      case (state_q)
         ST_IDLE, ST_HALT, ST_ERR: begin
            if (start) begin
               len_d = prog_len;
               pc_d  = '0;
               if (prog_len == CNT_W'(0)) begin
                  state_d = ST_HALT;
               end else begin
                  state_d = ST_ISSUE;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_ISSUE: begin
            pc_d = pc_q + CNT_W'(1);
`ifdef FETCH_TIMEOUT_EN
            wd_d = '0;
`endif
            // din_q holds the word being issued this cycle
            if (opcode_of(din_q) == OP_MVI) begin
               state_d = ST_IMM;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_IMM: begin
            pc_d    = pc_q + CNT_W'(1);
            state_d = ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
            wd_d    = '0;
`endif
         end
         ST_WAIT: begin
            if (Done) begin
               if (pc_q == len_q) begin
                  state_d = ST_HALT;
               end else begin
                  state_d = ST_ISSUE;
               end
            end else begin
`ifdef FETCH_TIMEOUT_EN
               if (wd_q == WD_W'(TIMEOUT - 1)) begin
                  state_d = ST_ERR;
               end else begin
                  wd_d = wd_q + WD_W'(1);
               end
`else
               state_d = ST_WAIT;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output register inputs, derived from the next state
   always_comb begin
      run_d    = (state_d == ST_ISSUE);
      busy_d   = (state_d == ST_ISSUE) || (state_d == ST_IMM) || (state_d == ST_WAIT);
      halted_d = (state_d == ST_HALT);
`ifdef FETCH_TIMEOUT_EN
      err_d    = (state_d == ST_ERR);
`endif
      if ((state_d == ST_ISSUE) || (state_d == ST_IMM)) begin
         din_d = rdata_s;
      end else begin
         din_d = din_q;
      end
   end

   // State, counters and output registers
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         len_q    <= '0;
         din_q    <= '0;
         run_q    <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         wd_q     <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         len_q    <= len_d;
         din_q    <= din_d;
         run_q    <= run_d;
         busy_q   <= busy_d;
         halted_q <= halted_d;
`ifdef FETCH_TIMEOUT_EN
         wd_q     <= wd_d;
         err_q    <= err_d;
`endif
      end
   end

   assign DIN    = din_q;
   assign Run    = run_q;
   assign pc     = pc_q[ADDR_W-1:0];
   assign busy   = busy_q;
   assign halted = halted_q;
`ifdef FETCH_TIMEOUT_EN
   assign err    = err_q;
`else
   assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed programs plus random
// programs, compared against a word-level model of the program memory.
module tb_instr_fetch_unit;
   localparam int DATA_W = 9;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic              Clock = 1'b0;
   logic              Resetn = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   prog_len = '0;
   logic              prog_we = 1'b0;
   logic [ADDR_W-1:0] prog_addr = '0;
   logic [DATA_W-1:0] prog_data = '0;
   logic              Done = 1'b0;
   logic [DATA_W-1:0] DIN;
   logic              Run;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              halted;
   logic              err;

   int checks   = 0;
   int failures = 0;
   logic [DATA_W-1:0] ref_mem [DEPTH];

   instr_fetch_unit dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .start     (start),
      .prog_len  (prog_len),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .Done      (Done),
      .DIN       (DIN),
      .Run       (Run),
      .pc        (pc),
      .busy      (busy),
      .halted    (halted),
      .err       (err)
   );

   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic load_word(input int a, input logic [DATA_W-1:0] d);
      prog_we   = 1'b1;
      prog_addr = ADDR_W'(a);
      prog_data = d;
      tick();
      prog_we   = 1'b0;
      ref_mem[a] = d;
   endtask

   // Random program whose last instruction is never an mvi without room
   // for its immediate word.
   task automatic gen_prog(input int len);
      logic [DATA_W-1:0] w [DEPTH];
      int p;
      for (int i = 0; i < DEPTH; i++) w[i] = DATA_W'($urandom);
      p = 0;
      while (p < len) begin
         if (w[p][2:0] == 3'b001) begin
            if (p == len - 1) begin
               w[p][2:0] = 3'b000;
               p = p + 1;
            end else begin
               p = p + 2;
            end
         end else begin
            p = p + 1;
         end
      end
      for (int i = 0; i < DEPTH; i++) load_word(i, w[i]);
   endtask

   // Runs a program of len words, playing the processor with random Done
   // latency; intrude writes RAM and pulses start during the first WAIT.
   task automatic run_prog(input int len, input bit intrude);
      int p;
      int d;
      int guard;
      bit intruded;
      logic [DATA_W-1:0] w;
      logic [DATA_W-1:0] last;
      p = 0;
      guard = 0;
      intruded = 1'b0;
      last = '0;
      prog_len = (ADDR_W+1)'(len);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (len == 0) begin
         check_eq("len0_halted", 32'(halted), 32'd1);
         check_eq("len0_run", 32'(Run), 32'd0);
         check_eq("len0_busy", 32'(busy), 32'd0);
         tick();
         check_eq("len0_run_after", 32'(Run), 32'd0);
         return;
      end
      while (p != len && guard < 80) begin
         guard++;
         w = ref_mem[p % DEPTH];
         check_eq("issue_run", 32'(Run), 32'd1);
         check_eq("issue_din", 32'(DIN), 32'(w));
         check_eq("issue_pc", 32'(pc), 32'(p % DEPTH));
         check_eq("issue_busy", 32'(busy), 32'd1);
         Done = 1'($urandom_range(0, 1));
         tick();
         p++;
         last = w;
         if (w[2:0] == 3'b001) begin
            w = ref_mem[p % DEPTH];
            check_eq("imm_run", 32'(Run), 32'd0);
            check_eq("imm_din", 32'(DIN), 32'(w));
            last = w;
            tick();
            p++;
         end
         Done = 1'b0;
         d = (intrude && !intruded) ? $urandom_range(1, 3) : $urandom_range(0, 3);
         for (int k = 0; k < d; k++) begin
            check_eq("wait_run", 32'(Run), 32'd0);
            check_eq("wait_din", 32'(DIN), 32'(last));
            check_eq("wait_busy", 32'(busy), 32'd1);
            if (intrude && !intruded) begin
               prog_we   = 1'b1;
               prog_addr = '0;
               prog_data = ~ref_mem[0];
               start     = 1'b1;
               intruded  = 1'b1;
            end
            tick();
            prog_we = 1'b0;
            start   = 1'b0;
         end
         Done = 1'b1;
         tick();
         Done = 1'b0;
      end
      check_eq("halt_halted", 32'(halted), 32'd1);
      check_eq("halt_busy", 32'(busy), 32'd0);
      check_eq("halt_run", 32'(Run), 32'd0);
      check_eq("halt_pc", 32'(pc), 32'(len % DEPTH));
      check_eq("halt_din", 32'(DIN), 32'(last));
      tick();
      check_eq("halt_hold", 32'(halted), 32'd1);
   endtask

   initial begin
      #12;
      check_eq("rst_run", 32'(Run), 32'd0);
      check_eq("rst_din", 32'(DIN), 32'd0);
      check_eq("rst_pc", 32'(pc), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      Resetn = 1'b1;
      tick();

      // mvi R0 with immediate, len=2
      load_word(0, 9'b011_000_001);
      load_word(1, 9'b111_001_111);
      run_prog(2, 1'b0);

      // mvi R2,1FFh followed by a non-mvi word, len=3
      load_word(0, 9'h0D1);
      load_word(1, 9'h1FF);
      load_word(2, 9'h0AA);
      run_prog(3, 1'b0);

      // empty program
      run_prog(0, 1'b0);

      // write and start while busy are dropped; rerun sees original RAM
      run_prog(3, 1'b1);
      run_prog(3, 1'b0);

      // asynchronous reset in the middle of WAIT
      prog_len = 6'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      Resetn = 1'b0;
      #1;
      check_eq("mid_rst_run", 32'(Run), 32'd0);
      check_eq("mid_rst_din", 32'(DIN), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_pc", 32'(pc), 32'd0);
      #2;
      Resetn = 1'b1;
      tick();
      check_eq("post_rst_busy", 32'(busy), 32'd0);
      run_prog(3, 1'b0);

      // random programs, including the full-depth length
      for (int it = 0; it < 6; it++) begin
         int len;
         len = (it == 0) ? DEPTH : $urandom_range(1, DEPTH);
         gen_prog(len);
         run_prog(len, 1'b0);
      end

      // Done never arrives
      load_word(0, 9'h0AA);
      prog_len = 6'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
`ifdef FETCH_TIMEOUT_EN
      repeat (63) tick();
      check_eq("wd_err_early", 32'(err), 32'd0);
      tick();
      check_eq("wd_err", 32'(err), 32'd1);
      check_eq("wd_busy", 32'(busy), 32'd0);
`else
      repeat (200) tick();
      check_eq("nowd_busy", 32'(busy), 32'd1);
      check_eq("nowd_err", 32'(err), 32'd0);
      check_eq("nowd_run", 32'(Run), 32'd0);
`endif
      Resetn = 1'b0;
      #2;
      Resetn = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
